// File: rtl/rca_accum_pkg.sv
// Shared types and default sizing for the rca_accum multi-operand accumulator.
package rca_accum_pkg;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_COUNT = 4;

endpackage

// File: rtl/rca_accum_rca.sv
// N-bit ripple-carry adder (module rca): sum[N] carries out of the top bit.
module rca #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N:0]   sum
);

  logic [N:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign sum[N] = carry_s[N];

endmodule

// File: rtl/rca_accum.sv
// Accumulates COUNT operands through one rca adder and presents sum + sticky overflow.
// Define RCA_ACCUM_SAT_EN to saturate the accumulator to all-ones on carry-out.
module rca_accum
  import rca_accum_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int COUNT = DEF_COUNT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

  state_t        state_r, state_s;
  logic [N-1:0]  acc_r, acc_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          ovf_r, ovf_s;
  logic [N:0]    sum_s;
  logic          accept_s;

  // Feedback adder: running sum on A, incoming operand on B.
  rca #(.N(N)) u_rca (
    .a    (acc_r),
    .b    (in_data),
    .c_in (1'b0),
    .sum  (sum_s)
  );

  // Handshake strobes come from registered state; rst forces both low.
  assign in_ready  = (state_r == ACC) & ~rst;
  assign out_valid = (state_r == OUT) & ~rst;
  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;
  assign accept_s  = in_valid & in_ready;

  // Next-state and datapath update for the ACC/OUT FSM.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    case (state_r)
      ACC: begin
        if (accept_s) begin
`ifdef RCA_ACCUM_SAT_EN
          acc_s = sum_s[N] ? {N{1'b1}} : sum_s[N-1:0];
`else
          acc_s = sum_s[N-1:0];
`endif
          ovf_s = ovf_r | sum_s[N];
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_s = OUT;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_s = ACC;
          acc_s   = {N{1'b0}};
          cnt_s   = {CW{1'b0}};
          ovf_s   = 1'b0;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = ACC;
        acc_s   = {N{1'b0}};
        cnt_s   = {CW{1'b0}};
        ovf_s   = 1'b0;
      end
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACC;
      acc_r   <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
    end
  end

endmodule

// File: tb/tb_rca_accum.sv
// Directed self-checking bench for rca_accum with N=4, COUNT=4.
module tb_rca_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  rca_accum #(.N(4), .COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 4'd0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b s=%0d o=%b want 0 0 0", out_valid, out_sum, out_ovf);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] ops [4];
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd3; ops[3] = 4'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      tick();
      if (i == 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd10 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got v=%b s=%0d o=%b r=%b want 1 10 0 0", out_valid, out_sum, out_ovf, in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_hs: got r=%b v=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [3:0] ops [4];
    logic [3:0] exp_sum;
`ifdef RCA_ACCUM_SAT_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd0;
`endif
    ops[0] = 4'd15; ops[1] = 4'd1; ops[2] = 4'd0; ops[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== exp_sum || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_result: got v=%b s=%0d o=%b want 1 %0d 1", out_valid, out_sum, out_ovf, exp_sum);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++;
    if (out_ovf !== 1'b0 || out_sum !== 4'd0) begin
      n_fail++; $display("FAIL ovf_cleared: got s=%0d o=%b want 0 0", out_sum, out_ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ops [4];
    ops[0] = 4'd5; ops[1] = 4'd5; ops[2] = 4'd5; ops[3] = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1; in_data = 4'd9;
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 4'd15 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b s=%0d o=%b r=%b want 1 15 0 0", c, out_valid, out_sum, out_ovf, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd15) begin
      n_fail++; $display("FAIL bp_final_hold: got v=%b s=%0d want 1 15", out_valid, out_sum);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_handshake: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 4'd0) begin
      n_fail++; $display("FAIL bp_single_hs: got v=%b s=%0d want 0 0", out_valid, out_sum);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_gaps();
    for (int c = 0; c < 7; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_data  = c[0] ? 4'd7 : 4'd2;
      tick();
      if (c == 5) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 4'd6) begin
          n_fail++; $display("FAIL gaps_partial: got v=%b s=%0d want 0 6", out_valid, out_sum);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd8 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL gaps_result: got v=%b s=%0d o=%b want 1 8 0", out_valid, out_sum, out_ovf);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_midreset();
    in_valid = 1'b1; in_data = 4'd7; tick(); tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_sum !== 4'd14) begin n_fail++; $display("FAIL mr_partial: got %0d want 14", out_sum); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_ready_in_rst: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 4'd0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL mr_cleared: got r=%b v=%b s=%0d o=%b want 1 0 0 0", in_ready, out_valid, out_sum, out_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd1;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd4 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL mr_result: got v=%b s=%0d o=%b want 1 4 0", out_valid, out_sum, out_ovf);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'd1;
      tick();
    end
    in_data = 4'd3;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd4) begin
      n_fail++; $display("FAIL b2b_first: got v=%b s=%0d want 1 4", out_valid, out_sum);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'd0) begin
      n_fail++; $display("FAIL b2b_hs_no_accept: got v=%b r=%b s=%0d want 0 1 0", out_valid, in_ready, out_sum);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 4'd9) begin
          n_fail++; $display("FAIL b2b_second_partial: got v=%b s=%0d want 0 9", out_valid, out_sum);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 4'd12 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got v=%b s=%0d o=%b want 1 12 0", out_valid, out_sum, out_ovf);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_accum.md
# rca_accum

Sequential multi-operand accumulator that consumes the `rca` ripple-carry adder's output.
- Accepts a stream of N-bit operands over a valid/ready handshake.
- Folds each accepted operand into a running sum through one `rca` instance.
- After COUNT operands, presents the total and a sticky overflow flag on a valid/ready output port.
- Sits directly downstream of the adder datapath: it closes the loop from `rca`'s sum back to `rca`'s operand A.

## Interface
Parameters:
- N, default 4: operand and accumulator width in bits.
- COUNT, default 4: operands summed per result; legal range is COUNT ≥ 1.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: in_data holds an operand.
- in_ready, output, 1: block can accept an operand this cycle.
- in_data, input, N: operand.
- out_valid, output, 1: out_sum and out_ovf hold a completed result.
- out_ready, input, 1: consumer takes the result this cycle.
- out_sum, output, N: accumulated sum, modulo 2^N (or saturated, see Configuration).
- out_ovf, output, 1: at least one carry-out occurred during this result's accumulation.

## Operation
- Two states: ACC and OUT.
- Registers:
  - acc[N-1:0]
  - cnt, $clog2(COUNT+1) bits
  - ovf
  - state
- Adder hookup: `rca` instance with a = acc, b = in_data, c_in = 0, giving sum[N:0]. sum[N] is the carry.
- ACC state:
  - in_ready = 1, out_valid = 0.
  - On accept (in_valid & in_ready):
    - acc <= sum[N-1:0]
    - ovf <= ovf | sum[N]
    - cnt <= cnt + 1
  - If the accept occurs with cnt == COUNT-1, the next state is OUT and cnt is left at COUNT.
- OUT state:
  - in_ready = 0, out_valid = 1.
  - out_sum = acc and out_ovf = ovf, held stable until the handshake.
  - On out_ready: next state is ACC, with acc <= 0, cnt <= 0, ovf <= 0.
- in_ready and out_valid are decoded from registered state only. Neither depends combinationally on in_valid or out_ready.
- No data changes while in_valid is low.
- in_data is ignored whenever in_ready = 0.

## Timing
- Reset values: state = ACC, acc = 0, cnt = 0, ovf = 0, out_valid = 0, out_sum = 0, out_ovf = 0.
- in_ready is 0 during any cycle in which rst is high, and 1 in the first cycle after rst deasserts.
- Reset mid-accumulation or in OUT: partial sum and pending result are discarded, with no output handshake.
- Latency: out_valid rises the cycle after the COUNT-th accept.
- Minimum period: COUNT+1 cycles per result with no stalls.
  - The first operand of the next batch can be accepted in the cycle after the out handshake.
  - It is not accepted in the handshake cycle itself.
- COUNT = 1: every accept goes straight to OUT.
- Overflow that happens on the COUNT-th operand still sets out_ovf.

## Configuration
- Macro: RCA_ACCUM_SAT_EN.
- Defined: on any accept with sum[N] = 1, acc <= all-ones instead of sum[N-1:0].
  - Later adds into a saturated acc keep it at all-ones.
  - ovf is set exactly as in the undefined case.
- Undefined: acc wraps modulo 2^N; out_ovf is the only overflow indication.

## Structure
- Package rca_accum_pkg holds:
  - the state enum typedef (ACC, OUT)
  - default localparams for N and COUNT
- One sub-module: the existing `rca` adder, instantiated once with parameter N.
- rca_accum itself holds all registers and the FSM. There is no other hierarchy.

## Test plan
All scenarios use N=4, COUNT=4.
- Operands 1, 2, 3, 4 on consecutive cycles, out_ready=1 → out_valid one cycle after the 4th accept, out_sum=10, out_ovf=0, and in_ready=1 the next cycle.
- Operands 15, 1, 0, 0:
  - without the macro → out_sum=0, out_ovf=1
  - with RCA_ACCUM_SAT_EN → out_sum=15, out_ovf=1
- Output backpressure: operands 5, 5, 5, 0 with out_ready held low for 5 cycles → out_sum=15 and out_valid=1 stable, in_ready=0 and in_valid pulses ignored; a later out_ready gives exactly one handshake.
- Input gaps: operands 2, 2, 2, 2 with in_valid toggling every other cycle → out_sum=8, and no extra accepts.
- Mid-operation reset: accept 7, 7, then a one-cycle rst → in_ready=0 during rst, then state returns to reset values; next batch 1, 1, 1, 1 → out_sum=4, out_ovf=0.
- Back-to-back batches (1, 1, 1, 1) then (3, 3, 3, 3) → results 4 then 12, second batch's first accept exactly one cycle after the first out handshake.
